multicycle_controller: RTL
==========================

Name: multicycle_controller

Overview:
- Multi-cycle sequencer for the RV32I datapath; replaces per-instruction combinational decode with a state machine that steps the shared ALU, register file, PC/IR registers and a single unified memory port through fetch, decode, execute, memory and write-back.
- Decodes the same opcode/funct fields and emits the same control encodings (imm_sel, wb_result_sel), plus memory handshake, register enables and multi-cycle ALU operand selects.

Parameters:
- OP_CODE_WIDTH, 7, opcode field width
- FUNCT3_WIDTH, 3, funct3 field width
- FUNCT7_WIDTH, 7, funct7 field width

Ports:
- i_clk  in  1  clock
- i_reset_n  in  1  asynchronous active-low reset
- i_op_code  in  OP_CODE_WIDTH  opcode from instruction register
- i_funct3  in  FUNCT3_WIDTH  funct3 from instruction register
- i_funct7  in  FUNCT7_WIDTH  funct7 from instruction register
- i_alu_zero_flag  in  1  ALU result == 0
- i_mem_ready  in  1  memory completes current request this cycle
- o_mem_req  out  1  memory request, held until i_mem_ready
- o_mem_we  out  1  write request (store)
- o_addr_sel  out  1  memory address: 0 = PC, 1 = ALU-out register
- o_ir_wr_en  out  1  latch fetched instruction and old PC
- o_pc_wr_en  out  1  update PC
- o_pc_src_sel  out  1  PC next: 0 = live ALU result, 1 = ALU-out register
- o_alu_src_a_sel  out  2  00 = PC, 01 = old PC, 10 = rs1
- o_alu_src_b_sel  out  2  00 = rs2, 01 = immediate, 10 = constant 4
- o_alu_op  out  4  {mod, funct3}; ADD = 0000, SUB = 1000
- o_imm_sel  out  2  00 = I, 01 = S, 10 = B, 11 = J
- o_reg_file_wr_en  out  1  register-file write
- o_wb_result_sel  out  2  00 = memory data, 01 = ALU-out, 10 = PC+4
- o_instr_retired  out  1  one-cycle pulse on the last cycle of each instruction
- o_illegal_instr  out  1  sticky; high in TRAP
- o_state  out  4  current state encoding (debug)

Behaviour:
- States/encoding: IDLE 0, FETCH 1, DECODE 2, MEM_ADDR 3, MEM_READ 4, MEM_WB 5, MEM_WRITE 6, EXEC_R 7, EXEC_I 8, ALU_WB 9, BRANCH 10, JAL 11, JALR 12, TRAP 15.
- Reset (asynchronous, any time, including mid-request): state = IDLE; all outputs 0. o_mem_req drops immediately.
- IDLE: all outputs 0; next cycle goes to FETCH.
- Outputs are state-decoded (Moore). Only o_ir_wr_en, o_pc_wr_en and o_instr_retired may also depend on inputs, as stated below. Any output not listed for a state is 0.
- Memory handshake: o_mem_req, o_mem_we and o_addr_sel stay stable from request until i_mem_ready is sampled high. i_mem_ready is ignored while o_mem_req = 0. Wait states are unbounded.
- FETCH: mem_req = 1, addr_sel = 0, a = 00, b = 10, ADD. When i_mem_ready = 1: ir_wr_en = 1, pc_wr_en = 1, pc_src = 0, then go to DECODE. Otherwise stay.
- DECODE: a = 01, b = 01, ADD (computes branch/JAL target). imm_sel follows the opcode: BRANCH → 10, JAL → 11, STORE → 01, else 00.
- DECODE next state: LOAD/STORE → MEM_ADDR; R_TYPE → EXEC_R; INT_IMMEDIATE → EXEC_I; BRANCH → BRANCH; JAL → JAL; JALR → JALR; any other opcode → TRAP.
- MEM_ADDR: a = 10, b = 01, ADD; imm_sel 01 for STORE, 00 for LOAD. Next: LOAD → MEM_READ, STORE → MEM_WRITE.
- MEM_READ: mem_req = 1, addr_sel = 1; on ready → MEM_WB.
- MEM_WB: reg_wr_en = 1, wb_sel = 00, retired = 1; → FETCH.
- MEM_WRITE: mem_req = 1, we = 1, addr_sel = 1; on ready: retired = 1, → FETCH.
- EXEC_R: a = 10, b = 00, alu_op = {funct7[5], funct3}; → ALU_WB.
- EXEC_I: a = 10, b = 01, alu_op = {funct3 == 101 ? funct7[5] : 0, funct3}; → ALU_WB.
- ALU_WB: reg_wr_en = 1, wb_sel = 01, retired = 1; → FETCH.
- BRANCH: a = 10, b = 00, SUB, pc_src = 1, retired = 1, → FETCH.
  - funct3 000 (BEQ): pc_wr_en = zero.
  - funct3 001 (BNE): pc_wr_en = !zero.
  - Any other funct3: go to TRAP instead, retired = 0.
- JAL: pc_wr_en = 1, pc_src = 1, reg_wr_en = 1, wb_sel = 10, retired = 1; → FETCH.
- JALR: a = 10, b = 01, ADD, pc_wr_en = 1, pc_src = 0, reg_wr_en = 1, wb_sel = 10, retired = 1; → FETCH.
- TRAP: illegal = 1; all other outputs 0; held until reset.
- Zero-wait latencies (cycles per instruction): R/I = 4, load = 5, store = 4, branch/JAL/JALR = 3.

Test Plan:
- Reset release, i_mem_ready = 1, R_TYPE funct7 = 0100000 funct3 = 000 → states 0,1,2,7,9,1. EXEC_R alu_op = 1000; ALU_WB reg_wr_en = 1, wb_sel = 01, retired pulse.
- LOAD with i_mem_ready held low for 3 cycles in both FETCH and MEM_READ → mem_req and addr_sel stable while waiting. Single ir_wr_en pulse. MEM_WB wb_sel = 00. 11 cycles FETCH-to-FETCH.
- BEQ with zero = 1 → pc_wr_en = 1, pc_src = 1. BNE with zero = 1 → pc_wr_en = 0. funct3 = 100 → TRAP, o_illegal_instr = 1, o_state = 15.
- JALR → pc_wr_en = 1, pc_src = 0, reg_wr_en = 1, wb_sel = 10. JAL → DECODE imm_sel = 11, then pc_src = 1.
- Opcode 7'b1111111 → TRAP held for 20 cycles regardless of inputs; reset returns to IDLE.
- i_reset_n asserted mid-MEM_WRITE while waiting → o_mem_req/o_mem_we drop without a clock edge. After release: IDLE then FETCH.

Source files
------------

// File: rtl/multicycle_controller_if.sv
// Handshake and control bundle between the multi-cycle sequencer and the RV32I datapath.
// master is the sequencer side; slave is the datapath/memory side.
interface multicycle_controller_if #(
  parameter int OP_CODE_WIDTH = 7,
  parameter int FUNCT3_WIDTH  = 3,
  parameter int FUNCT7_WIDTH  = 7
);
  logic [OP_CODE_WIDTH-1:0] i_op_code;
  logic [FUNCT3_WIDTH-1:0]  i_funct3;
  logic [FUNCT7_WIDTH-1:0]  i_funct7;
  logic                     i_alu_zero_flag;
  logic                     i_mem_ready;

  logic                     o_mem_req;
  logic                     o_mem_we;
  logic                     o_addr_sel;
  logic                     o_ir_wr_en;
  logic                     o_pc_wr_en;
  logic                     o_pc_src_sel;
  logic [1:0]               o_alu_src_a_sel;
  logic [1:0]               o_alu_src_b_sel;
  logic [3:0]               o_alu_op;
  logic [1:0]               o_imm_sel;
  logic                     o_reg_file_wr_en;
  logic [1:0]               o_wb_result_sel;
  logic                     o_instr_retired;
  logic                     o_illegal_instr;
  logic [3:0]               o_state;

  modport master (
    input  i_op_code, i_funct3, i_funct7, i_alu_zero_flag, i_mem_ready,
    output o_mem_req, o_mem_we, o_addr_sel, o_ir_wr_en, o_pc_wr_en, o_pc_src_sel,
           o_alu_src_a_sel, o_alu_src_b_sel, o_alu_op, o_imm_sel, o_reg_file_wr_en,
           o_wb_result_sel, o_instr_retired, o_illegal_instr, o_state
  );

  modport slave (
    output i_op_code, i_funct3, i_funct7, i_alu_zero_flag, i_mem_ready,
    input  o_mem_req, o_mem_we, o_addr_sel, o_ir_wr_en, o_pc_wr_en, o_pc_src_sel,
           o_alu_src_a_sel, o_alu_src_b_sel, o_alu_op, o_imm_sel, o_reg_file_wr_en,
           o_wb_result_sel, o_instr_retired, o_illegal_instr, o_state
  );
endinterface

// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I sequencer: steps the shared datapath through fetch, decode,
// execute, memory and write-back with Moore-decoded controls and a unified memory port.
module multicycle_controller #(
  parameter int OP_CODE_WIDTH = 7,
  parameter int FUNCT3_WIDTH  = 3,
  parameter int FUNCT7_WIDTH  = 7
) (
  input  logic                   i_clk,
  input  logic                   i_reset_n,
  multicycle_controller_if.master bus
);

  localparam logic [OP_CODE_WIDTH-1:0] OP_LOAD   = OP_CODE_WIDTH'(7'b0000011);
  localparam logic [OP_CODE_WIDTH-1:0] OP_STORE  = OP_CODE_WIDTH'(7'b0100011);
  localparam logic [OP_CODE_WIDTH-1:0] OP_R_TYPE = OP_CODE_WIDTH'(7'b0110011);
  localparam logic [OP_CODE_WIDTH-1:0] OP_INT_IMM = OP_CODE_WIDTH'(7'b0010011);
  localparam logic [OP_CODE_WIDTH-1:0] OP_BRANCH = OP_CODE_WIDTH'(7'b1100011);
  localparam logic [OP_CODE_WIDTH-1:0] OP_JAL    = OP_CODE_WIDTH'(7'b1101111);
  localparam logic [OP_CODE_WIDTH-1:0] OP_JALR   = OP_CODE_WIDTH'(7'b1100111);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_MEM_ADDR  = 4'd3,
    S_MEM_READ  = 4'd4,
    S_MEM_WB    = 4'd5,
    S_MEM_WRITE = 4'd6,
    S_EXEC_R    = 4'd7,
    S_EXEC_I    = 4'd8,
    S_ALU_WB    = 4'd9,
    S_BRANCH    = 4'd10,
    S_JAL       = 4'd11,
    S_JALR      = 4'd12,
    S_TRAP      = 4'd15
  } state_e;

  state_e state_q, state_d;

  logic       is_store;
  logic [2:0] f3;
  logic       f7b5;
  logic       unused_funct7;

  assign is_store      = (bus.i_op_code == OP_STORE);
  assign f3            = bus.i_funct3[2:0];
  assign f7b5          = bus.i_funct7[5];
  assign unused_funct7 = ^{bus.i_funct7[FUNCT7_WIDTH-1:6], bus.i_funct7[4:0]};

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) state_q <= S_IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d              = state_q;
    bus.o_mem_req        = 1'b0;
    bus.o_mem_we         = 1'b0;
    bus.o_addr_sel       = 1'b0;
    bus.o_ir_wr_en       = 1'b0;
    bus.o_pc_wr_en       = 1'b0;
    bus.o_pc_src_sel     = 1'b0;
    bus.o_alu_src_a_sel  = '0;
    bus.o_alu_src_b_sel  = '0;
    bus.o_alu_op         = '0;
    bus.o_imm_sel        = '0;
    bus.o_reg_file_wr_en = 1'b0;
    bus.o_wb_result_sel  = '0;
    bus.o_instr_retired  = 1'b0;
    bus.o_illegal_instr  = 1'b0;

    unique case (state_q)
      S_IDLE: state_d = S_FETCH;

      S_FETCH: begin
        bus.o_mem_req       = 1'b1;
        bus.o_alu_src_b_sel = 2'b10;
        if (bus.i_mem_ready) begin
          bus.o_ir_wr_en = 1'b1;
          bus.o_pc_wr_en = 1'b1;
          state_d        = S_DECODE;
        end
      end

      // The ALU speculatively forms old_PC + imm so BRANCH/JAL find the target ready.
      S_DECODE: begin
        bus.o_alu_src_a_sel = 2'b01;
        bus.o_alu_src_b_sel = 2'b01;
        case (bus.i_op_code)
          OP_BRANCH: bus.o_imm_sel = 2'b10;
          OP_JAL:    bus.o_imm_sel = 2'b11;
          OP_STORE:  bus.o_imm_sel = 2'b01;
          default:   bus.o_imm_sel = 2'b00;
        endcase
        case (bus.i_op_code)
          OP_LOAD, OP_STORE: state_d = S_MEM_ADDR;
          OP_R_TYPE:         state_d = S_EXEC_R;
          OP_INT_IMM:        state_d = S_EXEC_I;
          OP_BRANCH:         state_d = S_BRANCH;
          OP_JAL:            state_d = S_JAL;
          OP_JALR:           state_d = S_JALR;
          default:           state_d = S_TRAP;
        endcase
      end

      S_MEM_ADDR: begin
        bus.o_alu_src_a_sel = 2'b10;
        bus.o_alu_src_b_sel = 2'b01;
        bus.o_imm_sel       = is_store ? 2'b01 : 2'b00;
        state_d             = is_store ? S_MEM_WRITE : S_MEM_READ;
      end

      S_MEM_READ: begin
        bus.o_mem_req  = 1'b1;
        bus.o_addr_sel = 1'b1;
        if (bus.i_mem_ready) state_d = S_MEM_WB;
      end

      S_MEM_WB: begin
        bus.o_reg_file_wr_en = 1'b1;
        bus.o_wb_result_sel  = 2'b00;
        bus.o_instr_retired  = 1'b1;
        state_d              = S_FETCH;
      end

      S_MEM_WRITE: begin
        bus.o_mem_req  = 1'b1;
        bus.o_mem_we   = 1'b1;
        bus.o_addr_sel = 1'b1;
        if (bus.i_mem_ready) begin
          bus.o_instr_retired = 1'b1;
          state_d             = S_FETCH;
        end
      end

      S_EXEC_R: begin
        bus.o_alu_src_a_sel = 2'b10;
        bus.o_alu_src_b_sel = 2'b00;
        bus.o_alu_op        = {f7b5, f3};
        state_d             = S_ALU_WB;
      end

      // Only SRAI uses funct7[5]; other immediates carry imm bits there.
      S_EXEC_I: begin
        bus.o_alu_src_a_sel = 2'b10;
        bus.o_alu_src_b_sel = 2'b01;
        bus.o_alu_op        = {(f3 == 3'b101) & f7b5, f3};
        state_d             = S_ALU_WB;
      end

      S_ALU_WB: begin
        bus.o_reg_file_wr_en = 1'b1;
        bus.o_wb_result_sel  = 2'b01;
        bus.o_instr_retired  = 1'b1;
        state_d              = S_FETCH;
      end

      S_BRANCH: begin
        bus.o_alu_src_a_sel = 2'b10;
        bus.o_alu_src_b_sel = 2'b00;
        bus.o_alu_op        = 4'b1000;
        bus.o_pc_src_sel    = 1'b1;
        case (f3)
          3'b000: begin
            bus.o_pc_wr_en      = bus.i_alu_zero_flag;
            bus.o_instr_retired = 1'b1;
            state_d             = S_FETCH;
          end
          3'b001: begin
            bus.o_pc_wr_en      = ~bus.i_alu_zero_flag;
            bus.o_instr_retired = 1'b1;
            state_d             = S_FETCH;
          end
          default: state_d = S_TRAP;
        endcase
      end

      S_JAL: begin
        bus.o_pc_wr_en       = 1'b1;
        bus.o_pc_src_sel     = 1'b1;
        bus.o_reg_file_wr_en = 1'b1;
        bus.o_wb_result_sel  = 2'b10;
        bus.o_instr_retired  = 1'b1;
        state_d              = S_FETCH;
      end

      S_JALR: begin
        bus.o_alu_src_a_sel  = 2'b10;
        bus.o_alu_src_b_sel  = 2'b01;
        bus.o_pc_wr_en       = 1'b1;
        bus.o_reg_file_wr_en = 1'b1;
        bus.o_wb_result_sel  = 2'b10;
        bus.o_instr_retired  = 1'b1;
        state_d              = S_FETCH;
      end

      S_TRAP: bus.o_illegal_instr = 1'b1;

      default: state_d = S_TRAP;
    endcase
  end

  assign bus.o_state = state_q;

endmodule
